mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master, single-slave memory arbiter that shares one memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) of the multi-cycle NPC core. It accepts one request at a time, forwards it to the memory port, and routes the response back to the issuing master. A response watchdog bounds how long a master can wait. Ties between masters are broken round-robin.

## Interface
- TIMEOUT, default 255: cycles to wait in RESP for mem_rsp_valid before an error response is generated; 0 disables the watchdog.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- ifu_req_valid  in  1  IFU request present.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  32  IFU read address.
- ifu_rsp_valid  out  1  response for the IFU is valid.
- ifu_rsp_ready  in  1  IFU takes the response.
- ifu_rdata  out  32  read data returned to the IFU.
- ifu_rsp_err  out  1  IFU response is a timeout error.
- lsu_req_valid  in  1  LSU request present.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  32  LSU address.
- lsu_wen  in  1  LSU access is a write.
- lsu_wdata  in  32  LSU write data.
- lsu_wmask  in  4  LSU byte write mask.
- lsu_rsp_valid  out  1  response for the LSU is valid.
- lsu_rsp_ready  in  1  LSU takes the response.
- lsu_rdata  out  32  read data returned to the LSU (0 for writes).
- lsu_rsp_err  out  1  LSU response is a timeout error.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  32/1/32/4  registered request payload; IFU requests drive wen=0, wdata=0, wmask=0.
- mem_rsp_valid  in  1  memory response valid.
- mem_rsp_ready  out  1  arbiter accepts the memory response.
- mem_rdata  in  32  memory read data.

## Operation
- States: IDLE, REQ, RESP, DELIVER; state register `owner` (0=IFU, 1=LSU); register `last` holding the last granted master.
- IDLE: if exactly one master has req_valid, grant it. If both are valid, grant the master that is not `last`. The winner's req_ready is 1 combinationally in this cycle. The loser's req_ready is 0. On grant: latch the payload into the mem_* registers, set `owner` and `last`, go to REQ.
- REQ: mem_req_valid=1 with the payload held stable. On mem_req_ready=1, go to RESP and clear the watchdog counter.
- RESP: mem_rsp_ready=1. On mem_rsp_valid=1, capture mem_rdata (for writes, capture 0), set err=0, go to DELIVER.
  - Otherwise, if TIMEOUT≠0, increment the counter. When the counter reaches TIMEOUT-1 with no response, capture rdata=0, set err=1, go to DELIVER.
  - A mem_rsp_valid that arrives after the timeout is ignored (mem_rsp_ready=0 outside RESP).
- DELIVER: the owner's rsp_valid=1, with rdata/err held. The other master's rsp_valid=0. On the owner's rsp_ready=1, go to IDLE.
- The non-owner's req_ready is 0 in every state except IDLE. There is only one outstanding transaction.
- The watchdog counter is 8 bits wide, or wider if TIMEOUT>255 (width = clog2(TIMEOUT+1)), and saturates; it never wraps.

## Timing
- Reset (rst=1 at a clock edge) puts the block in IDLE with last=LSU (so the IFU wins the first tie) and owner=IFU.
  - All mem_* payload registers reset to 0; rdata=0; err=0; counter=0.
  - All valid/ready outputs are 0 except the combinational req_ready in IDLE.
- Reset asserted in any state aborts the transaction the following cycle. No rsp_valid is issued for the aborted request.
- Minimum latency, request accepted to rsp_valid: grant edge → REQ (cycle 1) → RESP (cycle 2) → DELIVER (cycle 3). With mem_req_ready=1 and mem_rsp_valid=1 on first sight, the owner sees rsp_valid 3 cycles after the accept cycle.
- Back-to-back: a new grant can occur in the cycle after DELIVER completes, giving a throughput of 1 transaction per 4 cycles minimum.
- Payload registers change only on a grant edge. Request inputs are sampled only in the grant cycle.

## Test plan
- Single IFU read: ifu_addr=0x80000000, memory ready immediately and returns 0x00000413 → ifu_req_ready in cycle 0, mem_req_valid in cycle 1, ifu_rsp_valid in cycle 3 with rdata=0x00000413 and err=0; lsu_rsp_valid stays 0.
- LSU write: addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF → mem_wen=1 with matching payload; lsu_rdata=0, lsu_rsp_err=0.
- Contention: both masters hold req_valid continuously for 4 transactions after reset → grant order IFU, LSU, IFU, LSU, each response routed to the correct master.
- Backpressure: hold mem_req_ready=0 for 5 cycles, then hold ifu_rsp_ready=0 for 3 cycles → mem_* and rsp payload stay stable throughout; no new grant until the response is taken.
- Timeout: TIMEOUT=4, memory never responds → owner rsp_valid=1 with err=1 and rdata=0 after 4 cycles in RESP; a late mem_rsp_valid is not accepted (mem_rsp_ready=0).
- Reset mid-RESP: assert rst → next cycle IDLE, mem_req_valid=0, no rsp_valid; the next tie is granted to the IFU.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the IFU and the LSU.
//
// One transaction is in flight at a time: a request is granted in IDLE,
// presented to memory in REQ, its response collected in RESP (bounded by a
// watchdog), and handed back to the issuing master in DELIVER. When both
// masters request together, the one not granted last time wins.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   ifu_req_*/ifu_addr          IFU read request (valid/ready handshake)
//   ifu_rsp_*/ifu_rdata         IFU response (rdata, timeout error flag)
//   lsu_req_*/lsu_addr/lsu_w*   LSU read/write request
//   lsu_rsp_*/lsu_rdata         LSU response (rdata is 0 for writes)
//   mem_req_*/mem_addr/mem_w*   registered request towards memory
//   mem_rsp_*/mem_rdata         memory response
// Parameter
//   TIMEOUT   cycles spent waiting in RESP before an error response is
//             produced; 0 disables the watchdog.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_rsp_valid,
    input  logic        ifu_rsp_ready,
    output logic [31:0] ifu_rdata,
    output logic        ifu_rsp_err,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_rsp_valid,
    input  logic        lsu_rsp_ready,
    output logic [31:0] lsu_rdata,
    output logic        lsu_rsp_err,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rdata
);

    // Watchdog counter is at least 8 bits, wider only when TIMEOUT needs it.
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RESP    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q,  last_d;
    logic [31:0]   addr_q,  addr_d;
    logic          wen_q,   wen_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wmask_q, wmask_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q,   err_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic gnt_ifu;
    logic gnt_lsu;
    logic owner_rsp_ready;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        gnt_ifu = 1'b0;
        gnt_lsu = 1'b0;
        owner_rsp_ready = (owner_q == M_LSU) ? lsu_rsp_ready : ifu_rsp_ready;

        case (state_q)
            IDLE: begin
                // A lone requester wins; on a tie the master not granted last wins.
                if (ifu_req_valid && (!lsu_req_valid || last_q == M_LSU)) begin
                    gnt_ifu = 1'b1;
                end else if (lsu_req_valid) begin
                    gnt_lsu = 1'b1;
                end

                if (gnt_ifu) begin
                    owner_d = M_IFU;
                    last_d  = M_IFU;
                    addr_d  = ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    state_d = REQ;
                end else if (gnt_lsu) begin
                    owner_d = M_LSU;
                    last_d  = M_LSU;
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    wmask_d = lsu_wmask;
                    state_d = REQ;
                end
            end

            REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end
            end

            RESP: begin
                // A real response takes priority over the watchdog in the same cycle.
                if (mem_rsp_valid) begin
                    rdata_d = wen_q ? 32'd0 : mem_rdata;
                    err_d   = 1'b0;
                    state_d = DELIVER;
                end else if (TIMEOUT != 0) begin
                    if (cnt_q == CNT_LAST) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = DELIVER;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            DELIVER: begin
                if (owner_rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= M_IFU;
            last_q  <= M_LSU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ifu_req_ready = gnt_ifu;
    assign lsu_req_ready = gnt_lsu;

    assign mem_req_valid = (state_q == REQ);
    assign mem_rsp_ready = (state_q == RESP);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    assign ifu_rsp_valid = (state_q == DELIVER) && (owner_q == M_IFU);
    assign lsu_rsp_valid = (state_q == DELIVER) && (owner_q == M_LSU);
    assign ifu_rdata     = rdata_q;
    assign lsu_rdata     = rdata_q;
    assign ifu_rsp_err   = err_q;
    assign lsu_rsp_err   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transactions against mem_arbiter
// (TIMEOUT=4), checked against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int n_chk  = 0;
    int n_fail = 0;
    bit last_m;   // model: 1 when the LSU was granted most recently

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
        .ifu_rdata(ifu_rdata), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
        .lsu_rdata(lsu_rdata), .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed hang, expected completion");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // While a transaction is in flight, random new requests must never be accepted.
    task automatic busy_noise();
        ifu_req_valid = 1'($urandom);
        lsu_req_valid = 1'($urandom);
        #1;
        chk("busy_ifu_req_ready", ifu_req_ready, 0);
        chk("busy_lsu_req_ready", lsu_req_ready, 0);
    endtask

    task automatic idle_inputs();
        ifu_req_valid = 0; lsu_req_valid = 0;
        ifu_rsp_ready = 0; lsu_rsp_ready = 0;
        mem_req_ready = 0; mem_rsp_valid = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        last_m = 1'b1;
    endtask

    // One complete transaction starting in IDLE (just after a rising edge).
    // req_wait: cycles mem_req_ready stays low; rsp_wait: RESP cycles before
    // memory answers (>= TO means never); dlv_wait: cycles owner stalls rsp_ready.
    task automatic run_txn(input bit iv, input bit lv,
                           input logic [31:0] ia, input logic [31:0] la, input bit lw,
                           input logic [31:0] lwd, input logic [3:0] lwm,
                           input int req_wait, input int rsp_wait, input int dlv_wait,
                           input logic [31:0] mrd, output bit won_lsu);
        bit w, eerr;
        logic [31:0] ea, ed, erd;
        logic ew;
        logic [3:0] em;
        w = (iv && lv) ? !last_m : lv;
        if (w) begin ea = la; ew = lw; ed = lwd; em = lwm; end
        else   begin ea = ia; ew = 0;  ed = 0;   em = 0;   end
        eerr = (rsp_wait >= TO);
        erd  = (eerr || ew) ? 32'd0 : mrd;

        idle_inputs();
        ifu_req_valid = iv; lsu_req_valid = lv;
        ifu_addr = ia; lsu_addr = la; lsu_wen = lw; lsu_wdata = lwd; lsu_wmask = lwm;
        #1;
        chk("grant_ifu_req_ready", ifu_req_ready, !w);
        chk("grant_lsu_req_ready", lsu_req_ready, w);
        @(posedge clk); #1;
        last_m = w; won_lsu = w;
        ifu_addr = $urandom; lsu_addr = $urandom; lsu_wdata = $urandom;
        lsu_wen = 1'($urandom); lsu_wmask = 4'($urandom);

        for (int k = 0; k <= req_wait; k++) begin
            chk("req_mem_req_valid", mem_req_valid, 1);
            chk("req_mem_addr", mem_addr, ea);
            chk("req_mem_wen", mem_wen, ew);
            chk("req_mem_wdata", mem_wdata, ed);
            chk("req_mem_wmask", mem_wmask, em);
            chk("req_mem_rsp_ready", mem_rsp_ready, 0);
            chk("req_rsp_valids", {ifu_rsp_valid, lsu_rsp_valid}, 0);
            mem_rsp_valid = 1'($urandom);
            busy_noise();
            mem_req_ready = (k == req_wait);
            @(posedge clk); #1;
        end
        mem_req_ready = 0; mem_rsp_valid = 0;

        for (int k = 0; k < TO; k++) begin
            chk("resp_mem_rsp_ready", mem_rsp_ready, 1);
            chk("resp_mem_req_valid", mem_req_valid, 0);
            chk("resp_rsp_valids", {ifu_rsp_valid, lsu_rsp_valid}, 0);
            busy_noise();
            mem_rsp_valid = (k == rsp_wait);
            mem_rdata = (k == rsp_wait) ? mrd : $urandom;
            @(posedge clk); #1;
            if (k == rsp_wait) break;
        end
        mem_rsp_valid = 0; mem_rdata = $urandom;

        for (int k = 0; k <= dlv_wait; k++) begin
            chk("dlv_ifu_rsp_valid", ifu_rsp_valid, !w);
            chk("dlv_lsu_rsp_valid", lsu_rsp_valid, w);
            chk("dlv_rdata", w ? lsu_rdata : ifu_rdata, erd);
            chk("dlv_err", w ? lsu_rsp_err : ifu_rsp_err, eerr);
            chk("dlv_mem_req_valid", mem_req_valid, 0);
            mem_rsp_valid = 1'($urandom);
            busy_noise();
            chk("dlv_mem_rsp_ready", mem_rsp_ready, 0);
            if (w) begin lsu_rsp_ready = (k == dlv_wait); ifu_rsp_ready = 1'($urandom); end
            else   begin ifu_rsp_ready = (k == dlv_wait); lsu_rsp_ready = 1'($urandom); end
            @(posedge clk); #1;
        end
        idle_inputs();
        chk("done_rsp_valids", {ifu_rsp_valid, lsu_rsp_valid}, 0);
        chk("done_mem_req_valid", mem_req_valid, 0);
    endtask

    initial begin
        bit w;
        int r;
        ifu_addr = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; mem_rdata = 0;
        do_reset();

        // Reset state
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_rsp_ready", mem_rsp_ready, 0);
        chk("rst_rsp_valids", {ifu_rsp_valid, lsu_rsp_valid}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wmask", mem_wmask, 0);
        chk("rst_rdata", ifu_rdata, 0);
        chk("rst_err", {ifu_rsp_err, lsu_rsp_err}, 0);
        chk("rst_req_readys", {ifu_req_ready, lsu_req_ready}, 0);

        // Single IFU read, minimum latency
        run_txn(1, 0, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0413, w);
        chk("ifu_read_owner", w, 0);

        // LSU write
        run_txn(0, 1, 0, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 32'h1234_5678, w);
        chk("lsu_write_owner", w, 1);

        // Contention after reset: IFU, LSU, IFU, LSU
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_txn(1, 1, $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom),
                    0, 0, 0, $urandom, w);
            chk("contention_order", w, (i % 2) == 1);
        end

        // Backpressure on both sides
        run_txn(1, 0, 32'h8000_0040, 0, 0, 0, 0, 5, 1, 3, 32'hCAFE_F00D, w);
        run_txn(0, 1, 0, 32'h8000_2000, 0, 0, 0, 2, 2, 3, 32'h0BAD_F00D, w);

        // Timeout: memory never answers
        run_txn(1, 0, 32'h8000_0100, 0, 0, 0, 0, 0, 100, 1, 32'hFFFF_FFFF, w);
        run_txn(0, 1, 0, 32'h8000_0200, 0, 0, 0, 1, TO, 0, 32'h5555_AAAA, w);
        // Response on the last allowed RESP cycle still wins
        run_txn(1, 0, 32'h8000_0300, 0, 0, 0, 0, 0, TO - 1, 0, 32'h7777_1111, w);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(1, 3);
            run_txn(r[0], r[1], $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 2),
                    $urandom, w);
        end

        // Reset mid-RESP
        idle_inputs();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0500;
        #1;
        chk("midrst_grant", ifu_req_ready, 1);
        @(posedge clk); #1;
        ifu_req_valid = 0; mem_req_ready = 1;
        @(posedge clk); #1;
        mem_req_ready = 0;
        chk("midrst_in_resp", mem_rsp_ready, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0; last_m = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("midrst_mem_req_valid", mem_req_valid, 0);
            chk("midrst_mem_rsp_ready", mem_rsp_ready, 0);
            chk("midrst_rsp_valids", {ifu_rsp_valid, lsu_rsp_valid}, 0);
            chk("midrst_mem_addr", mem_addr, 0);
            mem_rsp_valid = 1; mem_rdata = $urandom;
            @(posedge clk); #1;
        end
        mem_rsp_valid = 0;
        run_txn(1, 1, 32'h8000_0600, 32'h8000_0700, 0, 0, 0, 0, 0, 0, 32'h1111_2222, w);
        chk("midrst_tie_to_ifu", w, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
